// File: rtl/nco_quad_gen.sv
// Quadrature NCO: phase accumulator, 3-stage pipeline, quarter-wave sine table folded to cos/sin.
// Optional NCO_DITHER_EN adds LFSR phase dither ahead of index truncation.
module nco_quad_gen #(
    parameter int PHASE_W = 32,
    parameter int IDX_W   = 8,
    parameter int AMP_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [PHASE_W-1:0]       ftw_in,
    input  logic                     ftw_load,
    input  logic [PHASE_W-1:0]       poff_in,
    input  logic                     sync_clr,
    output logic signed [AMP_W-1:0]  cos_out,
    output logic signed [AMP_W-1:0]  sin_out,
    output logic                     out_valid
);

    localparam int N       = 1 << (IDX_W - 2);
    localparam int TIDX_W  = IDX_W - 1;
    localparam int AMP_MAX = (1 << (AMP_W - 1)) - 1;
    localparam logic [TIDX_W-1:0] N_IDX = TIDX_W'(N);

    // Taylor series keeps the table computable without relying on tool math builtins.
    function automatic int quarter_sine(input int k);
        real x;
        real term;
        real sum;
        int  v;
        x    = 1.5707963267948966 * real'(k) / real'(N);
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        v = $rtoi(real'(AMP_MAX) * sum + 0.5);
        if (v > AMP_MAX) v = AMP_MAX;
        if (v < 0) v = 0;
        return v;
    endfunction

    logic signed [AMP_W-1:0] quarter_table [0:N];

    generate
        for (genvar gi = 0; gi <= N; gi++) begin : g_table
            localparam int TVAL = quarter_sine(gi);
            assign quarter_table[gi] = AMP_W'(TVAL);
        end
    endgenerate

    logic [PHASE_W-1:0] acc_reg;
    logic [PHASE_W-1:0] ftw_reg;
    logic [PHASE_W-1:0] phase_sum;
    logic [IDX_W-1:0]   idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_reg <= '0;
        end else if (ftw_load) begin
            ftw_reg <= ftw_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + ftw_reg;
        end
    end

`ifdef NCO_DITHER_EN
    localparam int DITHER_SH = PHASE_W - IDX_W - 18;
    logic [15:0]        lfsr_reg;
    logic [PHASE_W-1:0] dither;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else if (en) begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
        end
    end

    // Dither stays below half an index LSB so it only decorrelates truncation error.
    assign dither    = PHASE_W'(lfsr_reg) << DITHER_SH;
    assign phase_sum = acc_reg + poff_in + dither;
`else
    assign phase_sum = acc_reg + poff_in;
`endif

    assign idx_next = IDX_W'(phase_sum >> (PHASE_W - IDX_W));

    // Stage 1: launch index from the pre-increment accumulator
    logic [IDX_W-1:0] idx_s1_reg;
    logic             v_s1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_s1_reg <= '0;
            v_s1_reg   <= 1'b0;
        end else begin
            v_s1_reg <= en;
            if (en) begin
                idx_s1_reg <= idx_next;
            end
        end
    end

    // Stage 2: registered dual read of the quarter table
    logic [1:0]              quad_s1;
    logic [TIDX_W-1:0]       r_idx;
    logic [TIDX_W-1:0]       nr_idx;
    logic [1:0]              q_s2_reg;
    logic signed [AMP_W-1:0] mag_r_s2_reg;
    logic signed [AMP_W-1:0] mag_nr_s2_reg;
    logic                    v_s2_reg;

    assign quad_s1 = idx_s1_reg[IDX_W-1:IDX_W-2];
    assign r_idx   = {1'b0, idx_s1_reg[IDX_W-3:0]};
    assign nr_idx  = N_IDX - r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_s2_reg      <= '0;
            mag_r_s2_reg  <= '0;
            mag_nr_s2_reg <= '0;
            v_s2_reg      <= 1'b0;
        end else begin
            v_s2_reg      <= v_s1_reg;
            q_s2_reg      <= quad_s1;
            mag_r_s2_reg  <= quarter_table[r_idx];
            mag_nr_s2_reg <= quarter_table[nr_idx];
        end
    end

    // Stage 3: quadrant folding
    logic signed [AMP_W-1:0] cos_next;
    logic signed [AMP_W-1:0] sin_next;
    logic signed [AMP_W-1:0] cos_reg;
    logic signed [AMP_W-1:0] sin_reg;
    logic                    out_valid_reg;

    always_comb begin
        cos_next = mag_nr_s2_reg;
        sin_next = mag_r_s2_reg;
        case (q_s2_reg)
            2'd0: begin
                sin_next = mag_r_s2_reg;
                cos_next = mag_nr_s2_reg;
            end
            2'd1: begin
                sin_next = mag_nr_s2_reg;
                cos_next = -mag_r_s2_reg;
            end
            2'd2: begin
                sin_next = -mag_r_s2_reg;
                cos_next = -mag_nr_s2_reg;
            end
            default: begin
                sin_next = -mag_nr_s2_reg;
                cos_next = mag_r_s2_reg;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cos_reg       <= '0;
            sin_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= v_s2_reg;
            if (v_s2_reg) begin
                cos_reg <= cos_next;
                sin_reg <= sin_next;
            end
        end
    end

    assign cos_out   = cos_reg;
    assign sin_out   = sin_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_nco_quad_gen.sv
// Directed bench for nco_quad_gen: default 8-bit instance plus a 12-bit/10-bit-index instance.
module tb_nco_quad_gen;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              ftw_load;
    logic              sync_clr;
    logic [31:0]       ftw_in;
    logic [31:0]       ftw_in_w;
    logic [31:0]       poff_in;
    logic signed [7:0] cos_out;
    logic signed [7:0] sin_out;
    logic              out_valid;
    logic signed [11:0] cos_w;
    logic signed [11:0] sin_w;
    logic              valid_w;

    int errors = 0;
    int checks = 0;
    int cos_q[$];
    int sin_q[$];
    int cosw_q[$];
    int sinw_q[$];

    int t3_idx[8] = '{1, 2, 3, 4, 64, 128, 192, 256};
    int t3_cos[8] = '{127, 127, 127, 126, 0, -127, 0, 127};
    int t3_sin[8] = '{3, 6, 9, 12, 127, 0, -127, 0};
    int t4_poff[4] = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000};
    int t4_cos[4] = '{127, 0, 0, 127};
    int t4_sin[4] = '{0, 127, -127, 0};
    int t5_cos[4] = '{123, 122, 121, 118};
    int t5_sin[4] = '{31, 34, 40, 46};

    always #5 clk = ~clk;

    nco_quad_gen dut (
        .clk(clk), .rst(rst), .en(en), .ftw_in(ftw_in), .ftw_load(ftw_load),
        .poff_in(poff_in), .sync_clr(sync_clr),
        .cos_out(cos_out), .sin_out(sin_out), .out_valid(out_valid)
    );

    nco_quad_gen #(.PHASE_W(32), .IDX_W(10), .AMP_W(12)) dut_w (
        .clk(clk), .rst(rst), .en(en), .ftw_in(ftw_in_w), .ftw_load(ftw_load),
        .poff_in(poff_in), .sync_clr(sync_clr),
        .cos_out(cos_w), .sin_out(sin_w), .out_valid(valid_w)
    );

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            cos_q.push_back(int'(cos_out));
            sin_q.push_back(int'(sin_out));
        end
        if (valid_w) begin
            cosw_q.push_back(int'(cos_w));
            sinw_q.push_back(int'(sin_w));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ftw_load = 1'b0; sync_clr = 1'b0; poff_in = '0;
        tick();
        rst = 1'b0;
        cos_q.delete(); sin_q.delete(); cosw_q.delete(); sinw_q.delete();
    endtask

    task automatic load_ftw();
        ftw_in = 32'h0100_0000; ftw_in_w = 32'h0040_0000; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n0;
        ftw_in = '0; ftw_in_w = '0;
        rst = 1'b1; en = 1'b0; ftw_load = 1'b0; sync_clr = 1'b0; poff_in = '0;
        tick_n(2);
        check("rst_valid", int'(out_valid), 0);
        check("rst_cos", int'(cos_out), 0);
        check("rst_sin", int'(sin_out), 0);

        // ftw=0, poff=0: latency and constant (127,0)
        do_reset();
        en = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 3);
        tick_n(7);
        en = 1'b0;
        tick_n(5);
        check("dc_count", cos_q.size(), 10);
        for (int i = 0; i < cos_q.size(); i++) begin
            check($sformatf("dc_cos[%0d]", i), cos_q[i], 127);
            check($sformatf("dc_sin[%0d]", i), sin_q[i], 0);
        end

        // ftw=2^24 sweep (and 2^22 on the wide instance)
        do_reset();
        load_ftw();
        en = 1'b1;
        tick_n(520);
        en = 1'b0;
        tick_n(5);
        check("sweep_count", cos_q.size(), 520);
        check("wide_count", cosw_q.size(), 520);
        check("sweep_cos[0]", cos_q[0], 127);
        check("sweep_sin[0]", sin_q[0], 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sweep_cos[%0d]", t3_idx[i]), cos_q[t3_idx[i]], t3_cos[i]);
            check($sformatf("sweep_sin[%0d]", t3_idx[i]), sin_q[t3_idx[i]], t3_sin[i]);
        end
        check("wide_cos[1]", cosw_q[1], 2047);
        check("wide_sin[1]", sinw_q[1], 13);
        check("wide_cos[256]", cosw_q[256], 0);
        check("wide_sin[256]", sinw_q[256], 2047);
        check("wide_cos[512]", cosw_q[512], -2047);
        check("wide_sin[512]", sinw_q[512], 0);

        // live phase offset takes effect on the sample launched that cycle
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            poff_in = t4_poff[i];
            tick();
        end
        en = 1'b0; poff_in = '0;
        tick_n(5);
        check("poff_count", cos_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("poff_cos[%0d]", i), cos_q[i], t4_cos[i]);
            check($sformatf("poff_sin[%0d]", i), sin_q[i], t4_sin[i]);
        end

        // ftw reload while running: indices 10, 11, 13, 15
        do_reset();
        load_ftw();
        en = 1'b1;
        tick_n(10);
        ftw_in = 32'h0200_0000; ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
        tick_n(5);
        en = 1'b0;
        tick_n(5);
        check("reload_count", cos_q.size(), 16);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reload_cos[%0d]", 10 + i), cos_q[10 + i], t5_cos[i]);
            check($sformatf("reload_sin[%0d]", 10 + i), sin_q[10 + i], t5_sin[i]);
        end

        // sync_clr mid-stream, then rst mid-stream
        do_reset();
        load_ftw();
        en = 1'b1;
        tick_n(5);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        tick_n(4);
        check("clr_cos[5]", cos_q[5], 126);
        check("clr_sin[5]", sin_q[5], 16);
        check("clr_cos[6]", cos_q[6], 127);
        check("clr_sin[6]", sin_q[6], 0);
        check("clr_cos[7]", cos_q[7], 127);
        check("clr_sin[7]", sin_q[7], 3);
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_cos", int'(cos_out), 0);
        check("midrst_sin", int'(sin_out), 0);
        n0 = cos_q.size();
        tick_n(6);
        check("midrst_stale", cos_q.size() - n0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
